// File: rtl/ram_fifo_ctrl.sv
// Synchronous FIFO controller in front of a single-port RAM; one RAM access per cycle, read/write arbitrated.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_EN is defined.
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              full,
    input  logic              rd_en,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
`ifdef FIFO_ERR_EN
    ,
    output logic              ovf,
    output logic              udf
`endif
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(2 ** ADDR_W);

    typedef enum logic {
        PRIO_RD,
        PRIO_WR
    } arb_t;

    arb_t              arb_q, arb_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              w_el, r_el, conflict, wr_gnt, rd_gnt;

    always_comb begin
        full     = (count_q == DEPTH);
        empty    = (count_q == '0);
        // Requests are masked during reset so no RAM access escapes while rst is high.
        w_el     = wr_en & ~full & ~rst;
        r_el     = rd_en & ~empty & ~rst;
        conflict = w_el & r_el;
        wr_gnt   = w_el & (~r_el | (arb_q == PRIO_WR));
        rd_gnt   = r_el & (~w_el | (arb_q == PRIO_RD));

        arb_d      = arb_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rd_valid_d = rd_gnt;

        if (conflict) begin
            arb_d = (arb_q == PRIO_RD) ? PRIO_WR : PRIO_RD;
        end
        if (wr_gnt) begin
            wptr_d  = wptr_q + 1'b1;
            count_d = count_q + 1'b1;
        end else if (rd_gnt) begin
            rptr_d  = rptr_q + 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_q      <= PRIO_RD;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            arb_q      <= arb_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign wr_ready    = wr_gnt;
    assign rd_ready    = rd_gnt;
    assign ram_wr      = wr_gnt;
    assign ram_rd      = rd_gnt;
    assign ram_add     = wr_gnt ? wptr_q : rptr_q;
    assign ram_data_in = wr_data;
    assign rd_data     = ram_data_out;
    assign rd_valid    = rd_valid_q;
    assign count       = count_q;

`ifdef FIFO_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (wr_en & full & ~rst);
        udf_d = udf_q | (rd_en & empty & ~rst);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

endmodule
